// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS.CC BCD stopwatch with start/stop, clear and lap freeze; define STOPWATCH_SATURATE_EN to hold at 59:59.99 instead of wrapping
module stopwatch_bcd #(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic        clear_in,
  input  logic        lap_in,
  output logic [23:0] bcd_out,
  output logic        running_out,
  output logic        lap_out,
  output logic        wrap_out
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [23:0] MAXV = 24'h595999;
  if (DIV < 1) begin : g_div_check
    $error("stopwatch_bcd: CLK_HZ/TICK_HZ must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [PW-1:0] psc;
  logic [23:0] count, snap, inc;
  logic [6:0] c;
  logic lap, wrap, tick;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < 6; i++) begin : g_dig
    logic at_max;
    assign at_max = count[4*i+:4] == MAXV[4*i+:4];
    assign inc[4*i+:4] = c[i] ? (at_max ? 4'd0 : count[4*i+:4] + 4'd1) : count[4*i+:4];
    assign c[i+1] = c[i] & at_max;
  end
  assign tick = state == RUN && psc == PW'(DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || clear_in) begin
      state <= IDLE;
      psc <= '0;
      count <= '0;
      snap <= '0;
      lap <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (state == RUN) psc <= tick ? '0 : psc + 1'b1;
      if (tick) begin
`ifdef STOPWATCH_SATURATE_EN
        if (c[6]) state <= PAUSE;
        else count <= inc;
`else
        count <= inc;
        wrap <= c[6];
`endif
      end
      if (start_in) state <= state == RUN ? PAUSE : RUN;
      if (lap_in && state != IDLE) begin
        lap <= !lap;
        if (!lap) snap <= count;
      end
    end
  end
  assign bcd_out = lap ? snap : count;
  assign running_out = state == RUN;
  assign lap_out = lap;
  assign wrap_out = wrap;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: checks two stopwatch_bcd instances (DIV=10 and DIV=1) against an arithmetic time model
module tb_stopwatch_bcd;
  logic clk = 0, rst = 1;
  logic s10 = 0, c10 = 0, l10 = 0, s1 = 0, c1 = 0, l1 = 0;
  logic [23:0] b10, b1;
  logic r10, lp10, w10, r1, lp1, w1;
  int n_assert = 0, n_fail = 0, n_wrap1 = 0;

  typedef struct {int st; int ph; int tot; bit lap; int snap; bit wrap;} m_t;
  m_t m10, m1;

  always #5 clk = ~clk;

  stopwatch_bcd #(.CLK_HZ(1000), .TICK_HZ(100)) u_d10 (.clk(clk), .rst(rst), .start_in(s10),
    .clear_in(c10), .lap_in(l10), .bcd_out(b10), .running_out(r10), .lap_out(lp10), .wrap_out(w10));
  stopwatch_bcd #(.CLK_HZ(100), .TICK_HZ(100)) u_d1 (.clk(clk), .rst(rst), .start_in(s1),
    .clear_in(c1), .lap_in(l1), .bcd_out(b1), .running_out(r1), .lap_out(lp1), .wrap_out(w1));

  // st: 0 idle, 1 run, 2 pause; tot is elapsed centiseconds
  function automatic m_t step(m_t m, int div, bit s, bit c, bit l);
    m_t n;
    bit tk;
    n = m;
    n.wrap = 0;
    tk = m.st == 1 && m.ph == div - 1;
    if (c) begin
      n = '{default: 0};
      return n;
    end
    if (m.st == 1) n.ph = tk ? 0 : m.ph + 1;
    if (tk) begin
      if (m.tot == 359999) begin
`ifdef STOPWATCH_SATURATE_EN
        n.st = 2;
`else
        n.tot = 0;
        n.wrap = 1;
`endif
      end else n.tot = m.tot + 1;
    end
    if (s) n.st = m.st == 1 ? 2 : 1;
    if (l && m.st != 0) begin
      n.lap = !m.lap;
      if (!m.lap) n.snap = m.tot;
    end
    return n;
  endfunction

  function automatic logic [23:0] to_bcd(int t);
    int mm, ss, cc;
    mm = t / 6000;
    ss = (t / 100) % 60;
    cc = t % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m10 <= '{default: 0};
      m1 <= '{default: 0};
    end else begin
      m10 <= step(m10, 10, s10, c10, l10);
      m1 <= step(m1, 1, s1, c1, l1);
    end
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp();
    chk("bcd10", b10, to_bcd(m10.lap ? m10.snap : m10.tot));
    chk("run10", 24'(r10), 24'(m10.st == 1));
    chk("lap10", 24'(lp10), 24'(m10.lap));
    chk("wrap10", 24'(w10), 24'(m10.wrap));
    chk("bcd1", b1, to_bcd(m1.lap ? m1.snap : m1.tot));
    chk("run1", 24'(r1), 24'(m1.st == 1));
    chk("lap1", 24'(lp1), 24'(m1.lap));
    chk("wrap1", 24'(w1), 24'(m1.wrap));
    if (w1) n_wrap1++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp();
      {s10, c10, l10, s1, c1, l1} = '0;
    end
  endtask

  task automatic p10(input bit s, input bit c, input bit l);
    @(negedge clk);
    cmp();
    {s10, c10, l10, s1, c1, l1} = {s, c, l, 3'b000};
  endtask

  task automatic p1(input bit s, input bit c, input bit l);
    @(negedge clk);
    cmp();
    {s10, c10, l10, s1, c1, l1} = {3'b000, s, c, l};
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    idle(50);
    chk("reset_bcd", b10, 24'h000000);
    chk("reset_run", 24'(r10), 24'd0);
    chk("reset_lap", 24'(lp10), 24'd0);
    chk("reset_wrap", 24'(w10), 24'd0);
    p10(1, 0, 0);
    idle(10);
    chk("first_tick_early", b10, 24'h000000);
    idle(1);
    chk("first_tick", b10, 24'h000001);
    idle(90);
    chk("run_100", b10, 24'h000010);
    p10(1, 0, 0);
    idle(51);
    chk("pause_hold", b10, 24'h000010);
    chk("pause_run", 24'(r10), 24'd0);
    p10(0, 1, 0);
    p10(1, 0, 0);
    idle(4);
    p10(1, 0, 0);
    idle(20);
    p10(1, 0, 0);
    idle(5);
    chk("phase_early", b10, 24'h000000);
    idle(1);
    chk("phase_tick", b10, 24'h000001);
    p10(0, 1, 0);
    p10(1, 0, 0);
    idle(1231);
    chk("lap_pre", b10, 24'h000123);
    p10(0, 0, 1);
    idle(30);
    chk("lap_frozen", b10, 24'h000123);
    chk("lap_flag", 24'(lp10), 24'd1);
    p10(0, 0, 1);
    idle(2);
    chk("lap_release", b10, 24'h000126);
    chk("lap_flag_off", 24'(lp10), 24'd0);
    p10(1, 0, 1);
    idle(1);
    chk("start_lap_bcd", b10, 24'h000126);
    chk("start_lap_run", 24'(r10), 24'd0);
    chk("start_lap_flag", 24'(lp10), 24'd1);
    p1(1, 0, 0);
    idle(6001);
    chk("carry_1min", b1, 24'h010000);
    idle(354000);
`ifdef STOPWATCH_SATURATE_EN
    chk("sat_bcd", b1, 24'h595999);
    chk("sat_run", 24'(r1), 24'd0);
    chk("sat_nowrap", 24'(n_wrap1), 24'd0);
    p1(1, 0, 0);
    idle(5);
    chk("sat_resume", b1, 24'h595999);
`else
    chk("wrap_bcd", b1, 24'h000000);
    chk("wrap_pulse", 24'(w1), 24'd1);
    chk("wrap_count", 24'(n_wrap1), 24'd1);
    chk("wrap_run", 24'(r1), 24'd1);
    idle(1);
    chk("wrap_once", 24'(w1), 24'd0);
`endif
    p1(1, 0, 0);
    idle(3);
    p1(1, 1, 1);
    idle(1);
    chk("clr_bcd", b1, 24'h000000);
    chk("clr_run", 24'(r1), 24'd0);
    chk("clr_lap", 24'(lp1), 24'd0);
    p1(0, 0, 1);
    idle(2);
    chk("idle_lap", 24'(lp1), 24'd0);
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
